// File: rtl/sig_lut_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sig_lut_arbiter
// Purpose  : Shares one sigmoid piecewise-linear LUT between N_REQ LSTM gate
//            requesters. A round-robin arbiter picks one request and drives
//            the LUT address from its integer bits. The result is either the
//            linear interpolation between the LUT base and next entries, or
//            the base entry alone. It is returned with a valid/ready
//            handshake. One transaction is in flight at a time.
//
// Build option:
//            SIG_LUT_INTERP_EN - when defined, CALC interpolates using the
//            fractional bits of x. When undefined, CALC returns the LUT base
//            value (step approximation). Latency is the same either way.
//
// Ports    : clk         - clock, rising edge
//            rst         - asynchronous reset, active low
//            req_valid   - per-requester request
//            req_x       - flattened signed inputs, lane i at [i*DATA_W +: DATA_W]
//            req_ready   - one-hot single-cycle accept pulse
//            lut_address - LUT address (integer bits of x, raw two's complement)
//            lut_base    - LUT base entry (combinational from lut_address)
//            lut_next    - LUT next entry (combinational from lut_address)
//            resp_valid  - result valid
//            resp_id     - index of the requester owning the result
//            resp_data   - signed sigmoid result
//            resp_ready  - consumer accepts result
//            busy        - high whenever the FSM is not idle
//
// Timing   : accept at cycle T, resp_valid first high at T+3. Minimum spacing
//            between grants is 4 cycles.
//
// Revision : 1.0 - initial release
// ============================================================================
module sig_lut_arbiter #(
  parameter int N_REQ  = 4,
  parameter int ADDR_W = 4,
  parameter int FRAC_W = 4,
  parameter int DATA_W = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [N_REQ*DATA_W-1:0]    req_x,
  output logic [N_REQ-1:0]           req_ready,
  output logic [ADDR_W-1:0]          lut_address,
  input  logic [DATA_W-1:0]          lut_base,
  input  logic [DATA_W-1:0]          lut_next,
  output logic                       resp_valid,
  output logic [$clog2(N_REQ)-1:0]   resp_id,
  output logic [DATA_W-1:0]          resp_data,
  input  logic                       resp_ready,
  output logic                       busy
);

  localparam int ID_W = $clog2(N_REQ);

  // --------------------------------------------------------------------------
  // Elaboration-time parameter sanity
  // --------------------------------------------------------------------------
  if (DATA_W != ADDR_W + FRAC_W) begin : g_bad_width
    $error("sig_lut_arbiter: DATA_W must equal ADDR_W + FRAC_W");
  end
  if (N_REQ < 2 || N_REQ > 8) begin : g_bad_nreq
    $error("sig_lut_arbiter: N_REQ must be in 2..8");
  end

  // --------------------------------------------------------------------------
  // State encoding
  // --------------------------------------------------------------------------
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_CALC  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t              r_state;
  logic [ID_W-1:0]     r_rr_ptr;
  logic [ADDR_W-1:0]   r_lut_address;
  logic [ID_W-1:0]     r_resp_id;
  logic [DATA_W-1:0]   r_resp_data;
  logic                r_resp_valid;
  logic [DATA_W-1:0]   r_base;

  // --------------------------------------------------------------------------
  // Round-robin search: first asserted request at or above r_rr_ptr, wrapping.
  // The rotated index is kept one bit wider so the wrap works for any N_REQ,
  // not only powers of two.
  // --------------------------------------------------------------------------
  logic                w_found;
  logic [ID_W-1:0]     w_grant_id;
  logic [ID_W:0]       w_idx;

  always_comb begin
    w_found    = 1'b0;
    w_grant_id = '0;
    w_idx      = '0;
    for (int k = 0; k < N_REQ; k++) begin
      w_idx = {1'b0, r_rr_ptr} + (ID_W+1)'(k);
      if (w_idx >= (ID_W+1)'(N_REQ)) begin
        w_idx = w_idx - (ID_W+1)'(N_REQ);
      end
      if (!w_found && req_valid[w_idx[ID_W-1:0]]) begin
        w_found    = 1'b1;
        w_grant_id = w_idx[ID_W-1:0];
      end
    end
  end

  // Pointer moves to the slot just after the winner.
  logic [ID_W-1:0] w_next_ptr;
  assign w_next_ptr = (w_grant_id == ID_W'(N_REQ - 1)) ? '0 : (w_grant_id + ID_W'(1));

  // Select the granted lane's x.
  logic [DATA_W-1:0] w_sel_x;

  always_comb begin
    w_sel_x = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_grant_id == ID_W'(i)) begin
        w_sel_x = req_x[i*DATA_W +: DATA_W];
      end
    end
  end

  // Accept pulse is combinational so that req_valid and req_ready meet in the
  // same cycle; it is masked while reset is held so nothing is accepted then.
  logic w_grant;
  assign w_grant = rst && (r_state == S_IDLE) && w_found;

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_ready
    assign req_ready[gi] = w_grant && (w_grant_id == ID_W'(gi));
  end

  // --------------------------------------------------------------------------
  // CALC datapath
  // --------------------------------------------------------------------------
  logic [DATA_W-1:0] w_result;

`ifdef SIG_LUT_INTERP_EN
  localparam int P_W = DATA_W + FRAC_W + 2;

  logic [FRAC_W-1:0]        r_frac;
  logic [DATA_W-1:0]        r_next;
  logic signed [DATA_W:0]   w_diff;
  logic signed [P_W-1:0]    w_diff_ext;
  logic signed [P_W-1:0]    w_frac_ext;
  logic signed [P_W-1:0]    w_prod;
  logic signed [P_W-1:0]    w_sum;
  logic [P_W-DATA_W:0]      w_sum_top;
  logic                     w_ovf;

  // One guard bit keeps next-base from overflowing.
  assign w_diff     = $signed({r_next[DATA_W-1], r_next}) - $signed({r_base[DATA_W-1], r_base});
  assign w_diff_ext = {{(FRAC_W+1){w_diff[DATA_W]}}, w_diff};
  assign w_frac_ext = {{(DATA_W+2){1'b0}}, r_frac};
  assign w_prod     = w_diff_ext * w_frac_ext;
  // Arithmetic shift floors toward negative infinity.
  assign w_sum      = {{(FRAC_W+2){r_base[DATA_W-1]}}, r_base} + (w_prod >>> FRAC_W);

  // In range iff every bit from the DATA_W sign position upward agrees.
  assign w_sum_top  = w_sum[P_W-1:DATA_W-1];
  assign w_ovf      = !((&w_sum_top) || !(|w_sum_top));

  always_comb begin
    w_result = w_sum[DATA_W-1:0];
    if (w_ovf) begin
      w_result = w_sum[P_W-1] ? {1'b1, {(DATA_W-1){1'b0}}}
                              : {1'b0, {(DATA_W-1){1'b1}}};
    end
  end
`else
  // Step approximation: the base entry is the answer; next and frac are unused.
  logic w_unused_interp;
  assign w_unused_interp = ^{lut_next, w_sel_x[FRAC_W-1:0]};
  assign w_result        = r_base;
`endif

  // --------------------------------------------------------------------------
  // Control FSM with registered outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= S_IDLE;
      r_rr_ptr      <= '0;
      r_lut_address <= '0;
      r_resp_id     <= '0;
      r_resp_data   <= '0;
      r_resp_valid  <= 1'b0;
      r_base        <= '0;
`ifdef SIG_LUT_INTERP_EN
      r_next        <= '0;
      r_frac        <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_resp_id     <= w_grant_id;
            r_lut_address <= w_sel_x[DATA_W-1:FRAC_W];
`ifdef SIG_LUT_INTERP_EN
            r_frac        <= w_sel_x[FRAC_W-1:0];
`endif
            r_rr_ptr      <= w_next_ptr;
            r_state       <= S_FETCH;
          end
        end
        S_FETCH: begin
          // LUT outputs settle from the address registered on the grant cycle.
          r_base  <= lut_base;
`ifdef SIG_LUT_INTERP_EN
          r_next  <= lut_next;
`endif
          r_state <= S_CALC;
        end
        S_CALC: begin
          r_resp_data  <= w_result;
          r_resp_valid <= 1'b1;
          r_state      <= S_RESP;
        end
        S_RESP: begin
          if (resp_ready) begin
            r_resp_valid <= 1'b0;
            r_state      <= S_IDLE;
          end
        end
        default: begin
          r_state      <= S_IDLE;
          r_resp_valid <= 1'b0;
        end
      endcase
    end
  end

  assign lut_address = r_lut_address;
  assign resp_valid  = r_resp_valid;
  assign resp_id     = r_resp_id;
  assign resp_data   = r_resp_data;
  assign busy        = (r_state != S_IDLE);

endmodule
`default_nettype wire
